// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the data-RAM port arbiter.
// Holds the controller state encoding, port identifiers, the
// response record captured at grant time and the address check.
package ram_arb_pkg;

    // Controller state: zero-fill walk, then normal arbitration.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Port identifiers stored in the response record.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // What the response cycle needs to know about the granted access.
    typedef struct packed {
        logic port;     // PORT_I or PORT_D
        logic is_read;  // fetch or load (store responses carry no data)
        logic err;      // misaligned or out-of-range
    } resp_t;

    // A byte address is rejected when it is not word aligned or when any
    // bit above the RAM word-address field is set.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] hi;
        hi = addr >> (aw + 2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter (fetch port I, load/store port D).
// Grants are combinational from the current requests; the last-grant
// flag remembers who won most recently so the other side wins a tie.
module rr_arb2 (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    // 1 = D was granted last; resets to 1 so I wins the first tie.
    logic last_d;

    // Pick a winner this cycle: a lone requester wins, a tie goes to the
    // port that did not win last time.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (en) begin
            if (req_i && req_d) begin
                if (last_d) begin
                    gnt_i = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
    end

    // Remember the most recent winner on every grant.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_d <= 1'b1;
        end else if (gnt_i || gnt_d) begin
            last_d <= gnt_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port data RAM between the fetch port (I) and the
// load/store port (D). After reset it optionally zero-fills the RAM, then
// grants at most one access per cycle round-robin. Each granted access
// gets exactly one response the following cycle; bad addresses are
// granted but never touch the RAM and respond with err=1.
//
// Handshake: a port raises x_req with its address/data and holds them
// until x_gnt is seen high in the same cycle; the access is committed at
// that clock edge and x_rvalid pulses for one cycle on the next cycle.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 32,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          clr_n,
    output logic          init_done,
    // fetch port
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    // load/store port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    // RAM side
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic          mem_read,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // controller state, for observation only
    output state_t        dbg_state
);

    localparam state_t RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] init_cnt;
    logic          resp_vld;
    resp_t         resp_q;

    logic          run_en;
    logic          any_gnt;
    logic [31:0]   sel_addr;
    logic          sel_read;
    logic          sel_err;

    // Grants only exist in RUN and never while reset is asserted.
    assign run_en = clr_n && (state == ST_RUN);

    rr_arb2 u_arb (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (run_en),
        .req_i (i_req),
        .req_d (d_req),
        .gnt_i (i_gnt),
        .gnt_d (d_gnt)
    );

    // Describe the access being granted this cycle (if any).
    always_comb begin
        any_gnt  = i_gnt || d_gnt;
        sel_addr = d_gnt ? d_addr : i_addr;
        sel_read = d_gnt ? !d_we : 1'b1;
        sel_err  = addr_bad(sel_addr, AW);
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT on the cycle that writes the last word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_cnt == '1) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = RST_STATE;
        endcase
    end

    // Zero-fill word counter; wraps back to 0 as INIT finishes.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + AW'(1);
        end
    end

    // RAM strobes and init_done. Everything is forced low while clr_n is
    // low so the reset state is visible immediately on all outputs.
    always_comb begin
        init_done = 1'b0;
        mem_addr  = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_wdata = '0;
        if (clr_n) begin
            if (state == ST_INIT) begin
                mem_addr  = init_cnt;
                mem_write = 1'b1;
            end else begin
                init_done = 1'b1;
                if (any_gnt && !sel_err) begin
                    mem_addr = sel_addr[AW+1:2];
                    if (sel_read) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        mem_wdata = d_wdata;
                    end
                end
            end
        end
    end

    // Capture who was granted and how to answer; valid for one cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            resp_vld <= 1'b0;
            resp_q   <= '0;
        end else begin
            resp_vld <= any_gnt;
            if (any_gnt) begin
                resp_q.port    <= d_gnt ? PORT_D : PORT_I;
                resp_q.is_read <= sel_read;
                resp_q.err     <= sel_err;
            end
        end
    end

    // Route the registered response to its port; RAM data only for good reads.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        if (clr_n && resp_vld) begin
            if (resp_q.port == PORT_I) begin
                i_rvalid = 1'b1;
                i_err    = resp_q.err;
                if (resp_q.is_read && !resp_q.err) i_rdata = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_err    = resp_q.err;
                if (resp_q.is_read && !resp_q.err) d_rdata = mem_rdata;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a zero-fill instance with a RAM
// model, and a no-init instance for the straight-to-RUN path.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_n  = 1'b0;
    logic clr1_n = 1'b0;

    // ---------------- DUT 0 (INIT_ZERO=1) ----------------
    logic        init_done;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [9:0]  mem_addr;
    logic        mem_write, mem_read;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    state_t      dbg_state;

    ram_port_arbiter #(.AW(10), .DW(32), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .clr_n(clr_n), .init_done(init_done),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // RAM model: registered read, write lands at the edge. Seeded with
    // non-zero contents so the zero-fill is observable.
    logic [31:0] ram [1024];
    logic        seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hA5A5_0000 | 32'(i);
            seeded <= 1'b1;
        end else begin
            if (mem_write) ram[mem_addr] <= mem_wdata;
            if (mem_read)  mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- DUT 1 (INIT_ZERO=0) ----------------
    logic        init_done1;
    logic        i_req1 = 1'b0;
    logic [31:0] i_addr1 = '0;
    logic        i_gnt1, i_rvalid1, i_err1;
    logic [31:0] i_rdata1;
    logic        d_gnt1, d_rvalid1, d_err1;
    logic [31:0] d_rdata1;
    logic [9:0]  mem_addr1;
    logic        mem_write1, mem_read1;
    logic [31:0] mem_wdata1;
    logic [31:0] mem_rdata1 = 32'h0BAD_F00D;
    state_t      dbg_state1;

    ram_port_arbiter #(.AW(10), .DW(32), .INIT_ZERO(1'b0)) dut1 (
        .clk(clk), .clr_n(clr1_n), .init_done(init_done1),
        .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1),
        .i_rdata(i_rdata1), .i_err(i_err1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1), .d_err(d_err1),
        .mem_addr(mem_addr1), .mem_write(mem_write1), .mem_read(mem_read1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".init_done"}, 32'(init_done), 0);
        check({tag, ".i_gnt"},     32'(i_gnt), 0);
        check({tag, ".i_rvalid"},  32'(i_rvalid), 0);
        check({tag, ".i_rdata"},   i_rdata, 0);
        check({tag, ".i_err"},     32'(i_err), 0);
        check({tag, ".d_gnt"},     32'(d_gnt), 0);
        check({tag, ".d_rvalid"},  32'(d_rvalid), 0);
        check({tag, ".d_rdata"},   d_rdata, 0);
        check({tag, ".d_err"},     32'(d_err), 0);
        check({tag, ".mem_addr"},  32'(mem_addr), 0);
        check({tag, ".mem_write"}, 32'(mem_write), 0);
        check({tag, ".mem_read"},  32'(mem_read), 0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_igt, e_dgt, e_rd, e_wr;
        logic [9:0]  e_maddr;
        logic [31:0] e_mwdata;
        logic        e_irv;
        logic [31:0] e_irdata;
        logic        e_ierr;
        logic        e_drv;
        logic [31:0] e_drdata;
        logic        e_derr;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic igt, input logic dgt, input logic rd, input logic wr,
        input logic [9:0] ma, input logic [31:0] mwd,
        input logic irv, input logic [31:0] ird, input logic ie,
        input logic drv, input logic [31:0] drd, input logic de);
        vec_t v;
        v.i_req = ir;  v.i_addr = ia;
        v.d_req = dr;  v.d_we = dw;  v.d_addr = da;  v.d_wdata = dd;
        v.e_igt = igt; v.e_dgt = dgt; v.e_rd = rd; v.e_wr = wr;
        v.e_maddr = ma; v.e_mwdata = mwd;
        v.e_irv = irv; v.e_irdata = ird; v.e_ierr = ie;
        v.e_drv = drv; v.e_drdata = drd; v.e_derr = de;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        check({t, ".init_done"}, 32'(init_done), 1);
        check({t, ".i_gnt"},     32'(i_gnt), 32'(v.e_igt));
        check({t, ".d_gnt"},     32'(d_gnt), 32'(v.e_dgt));
        check({t, ".mem_read"},  32'(mem_read), 32'(v.e_rd));
        check({t, ".mem_write"}, 32'(mem_write), 32'(v.e_wr));
        check({t, ".mem_addr"},  32'(mem_addr), 32'(v.e_maddr));
        check({t, ".mem_wdata"}, mem_wdata, v.e_mwdata);
        check({t, ".i_rvalid"},  32'(i_rvalid), 32'(v.e_irv));
        check({t, ".i_rdata"},   i_rdata, v.e_irdata);
        check({t, ".i_err"},     32'(i_err), 32'(v.e_ierr));
        check({t, ".d_rvalid"},  32'(d_rvalid), 32'(v.e_drv));
        check({t, ".d_rdata"},   d_rdata, v.e_drdata);
        check({t, ".d_err"},     32'(d_err), 32'(v.e_derr));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        //          i_req i_addr      d_req we d_addr        d_wdata        | igt dgt rd wr maddr mwdata        | irv irdata        ie | drv drdata        de
        vecs[0]  = mk(1, 32'h0,    0, 0, 32'h0,    32'h0,          1, 0, 1, 0, 10'd0,    32'h0,          0, 32'h0,          0, 0, 32'h0,          0);
        vecs[1]  = mk(0, 32'h0,    1, 1, 32'h10,   32'hDEADBEEF,   0, 1, 0, 1, 10'd4,    32'hDEADBEEF,   1, 32'h0,          0, 0, 32'h0,          0);
        vecs[2]  = mk(0, 32'h0,    1, 0, 32'h10,   32'h0,          0, 1, 1, 0, 10'd4,    32'h0,          0, 32'h0,          0, 1, 32'h0,          0);
        vecs[3]  = mk(0, 32'h0,    1, 1, 32'h0,    32'hCAFE0000,   0, 1, 0, 1, 10'd0,    32'hCAFE0000,   0, 32'h0,          0, 1, 32'hDEADBEEF,   0);
        vecs[4]  = mk(0, 32'h0,    1, 1, 32'h4,    32'h12345678,   0, 1, 0, 1, 10'd1,    32'h12345678,   0, 32'h0,          0, 1, 32'h0,          0);
        vecs[5]  = mk(1, 32'h0,    1, 0, 32'h4,    32'h0,          1, 0, 1, 0, 10'd0,    32'h0,          0, 32'h0,          0, 1, 32'h0,          0);
        vecs[6]  = mk(1, 32'h0,    1, 0, 32'h4,    32'h0,          0, 1, 1, 0, 10'd1,    32'h0,          1, 32'hCAFE0000,   0, 0, 32'h0,          0);
        vecs[7]  = mk(1, 32'h0,    1, 0, 32'h4,    32'h0,          1, 0, 1, 0, 10'd0,    32'h0,          0, 32'h0,          0, 1, 32'h12345678,   0);
        vecs[8]  = mk(1, 32'h0,    1, 0, 32'h4,    32'h0,          0, 1, 1, 0, 10'd1,    32'h0,          1, 32'hCAFE0000,   0, 0, 32'h0,          0);
        vecs[9]  = mk(1, 32'h1000, 1, 0, 32'h12,   32'h0,          1, 0, 0, 0, 10'd0,    32'h0,          0, 32'h0,          0, 1, 32'h12345678,   0);
        vecs[10] = mk(0, 32'h0,    1, 0, 32'h12,   32'h0,          0, 1, 0, 0, 10'd0,    32'h0,          1, 32'h0,          1, 0, 32'h0,          0);
        vecs[11] = mk(0, 32'h0,    1, 1, 32'h4000, 32'hFFFFFFFF,   0, 1, 0, 0, 10'd0,    32'h0,          0, 32'h0,          0, 1, 32'h0,          1);
        vecs[12] = mk(0, 32'h0,    0, 0, 32'h0,    32'h0,          0, 0, 0, 0, 10'd0,    32'h0,          0, 32'h0,          0, 1, 32'h0,          1);
        vecs[13] = mk(0, 32'h0,    1, 0, 32'h4,    32'h0,          0, 1, 1, 0, 10'd1,    32'h0,          0, 32'h0,          0, 0, 32'h0,          0);
        vecs[14] = mk(1, 32'hFFC,  0, 0, 32'h0,    32'h0,          1, 0, 1, 0, 10'd1023, 32'h0,          0, 32'h0,          0, 1, 32'h12345678,   0);
        vecs[15] = mk(0, 32'h0,    0, 0, 32'h0,    32'h0,          0, 0, 0, 0, 10'd0,    32'h0,          1, 32'h0,          0, 0, 32'h0,          0);

        // Reset state of DUT 0 with both requests raised.
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h10; i_addr = 32'h0;
        i_req1 = 1'b1; i_addr1 = 32'h8;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_all_zero("reset");
        check("reset.init_done1", 32'(init_done1), 0);
        check("reset.i_gnt1",     32'(i_gnt1), 0);
        check("reset.mem_read1",  32'(mem_read1), 0);

        // No-init instance: RUN straight out of reset, request granted at once.
        @(negedge clk);
        clr1_n = 1'b1;
        #1;
        check("noinit.init_done", 32'(init_done1), 1);
        check("noinit.i_gnt",     32'(i_gnt1), 1);
        check("noinit.mem_read",  32'(mem_read1), 1);
        check("noinit.mem_addr",  32'(mem_addr1), 2);
        @(negedge clk);
        i_req1 = 1'b0;
        #1;
        check("noinit.i_rvalid",  32'(i_rvalid1), 1);
        check("noinit.i_rdata",   i_rdata1, 32'h0BAD_F00D);
        check("noinit.d_rvalid",  32'(d_rvalid1), 0);

        // Zero-fill walk with a fetch request held high the whole time.
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0;
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            check($sformatf("init%0d.mem_addr", k), 32'(mem_addr), 32'(k));
            check($sformatf("init%0d.mem_write", k), 32'(mem_write), 1);
            check($sformatf("init%0d.mem_wdata", k), mem_wdata, 0);
            check($sformatf("init%0d.i_gnt", k), 32'(i_gnt), 0);
            check($sformatf("init%0d.init_done", k), 32'(init_done), 0);
        end

        // Normal operation, one table row per cycle.
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            apply_vec(vecs[v]);
            #1;
            check_vec(vecs[v], v);
        end
        check("run.dbg_state", 32'(dbg_state), 32'(ST_RUN));

        // Reset dropped in the cycle after a load grant: response is lost.
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        #1;
        check("rstmid.d_gnt",    32'(d_gnt), 1);
        check("rstmid.mem_read", 32'(mem_read), 1);
        @(negedge clk);
        d_req = 1'b0;
        clr_n = 1'b0;
        #1;
        check_all_zero("rstmid_a");
        @(negedge clk); #1;
        check_all_zero("rstmid_b");
        check("rstmid.dbg_state", 32'(dbg_state), 32'(ST_INIT));
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0;
        clr_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            check($sformatf("reinit%0d.mem_addr", k), 32'(mem_addr), 32'(k));
            check($sformatf("reinit%0d.mem_write", k), 32'(mem_write), 1);
            check($sformatf("reinit%0d.init_done", k), 32'(init_done), 0);
            check($sformatf("reinit%0d.i_gnt", k), 32'(i_gnt), 0);
            check($sformatf("reinit%0d.d_rvalid", k), 32'(d_rvalid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
